// File: rtl/md_sched.sv
// Multiply/divide scheduler: holds HI/LO, models fixed mult/div latency with an
// IDLE/BUSY FSM and raises the decode-stage stall for HI/LO users.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   quot, rem;
  logic          div_by_zero;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign div_by_zero = (src_b == 32'd0);

  // Zero divisor and the signed overflow case are steered away from the divider.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (!div_by_zero) begin
      if (md_op == 3'd3) begin
        if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
          quot = 32'h8000_0000;
          rem  = 32'd0;
        end else begin
          quot = $signed(src_a) / $signed(src_b);
          rem  = $signed(src_a) % $signed(src_b);
        end
      end else begin
        quot = src_a / src_b;
        rem  = src_a % src_b;
      end
    end
  end

  // NOTE: every next-state variable gets its hold value first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (md_op)
          3'd1, 3'd2: begin
            {pend_hi_d, pend_lo_d} = (md_op == 3'd1) ? prod_s : prod_u;
            pend_valid_d = 1'b1;
            cnt_d        = MULT_LOAD;
            state_d      = S_BUSY;
          end
          3'd3, 3'd4: begin
            pend_hi_d    = rem;
            pend_lo_d    = quot;
            pend_valid_d = !div_by_zero;
            cnt_d        = DIV_LOAD;
            state_d      = S_BUSY;
          end
          3'd5:    hi_d = src_a;
          3'd6:    lo_d = src_a;
          default: ;
        endcase
      end
      S_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign start = (md_op >= 3'd1) && (md_op <= 3'd4) && (state_q == S_IDLE);
  assign busy  = (state_q == S_BUSY);
  assign stall = d_md_use & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched: latency, results, stall and reset abort.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        d_md_use;
  logic        start, busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .d_md_use(d_md_use), .start(start), .busy(busy), .hi(hi), .lo(lo), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle, check every busy cycle, then the completion cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit inject);
    md_op = op; src_a = a; src_b = b; d_md_use = 1'b1;
    #1;
    check({tag, " start"}, {31'd0, start}, 32'd1);
    check({tag, " stall@start"}, {31'd0, stall}, 32'd1);
    check({tag, " busy@start"}, {31'd0, busy}, 32'd0);
    tick();
    for (int i = 1; i <= cycles; i++) begin
      if (inject && i == 2) begin
        md_op = 3'd5; src_a = 32'hDEAD_BEEF;
      end else begin
        md_op = 3'd0;
      end
      #1;
      check($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s stall c%0d", tag, i), {31'd0, stall}, 32'd1);
      check($sformatf("%s start c%0d", tag, i), {31'd0, start}, 32'd0);
      check($sformatf("%s hi hold c%0d", tag, i), hi, model_hi);
      check($sformatf("%s lo hold c%0d", tag, i), lo, model_lo);
      tick();
    end
    md_op = 3'd0; d_md_use = 1'b1;
    #1;
    check({tag, " busy done"}, {31'd0, busy}, 32'd0);
    check({tag, " stall done"}, {31'd0, stall}, 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    reset = 1'b1; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0; d_md_use = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 7/0", 3'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div x/0", 3'd3, 32'd9, 32'd0, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

    md_op = 3'd5; src_a = 32'h1234_5678; d_md_use = 1'b0;
    #1;
    check("mthi start", {31'd0, start}, 32'd0);
    tick();
    md_op = 3'd6; src_a = 32'h9ABC_DEF0;
    #1;
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi busy", {31'd0, busy}, 32'd0);
    tick();
    md_op = 3'd0;
    #1;
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi", hi, 32'h1234_5678);
    check("mtlo busy", {31'd0, busy}, 32'd0);

    md_op = 3'd3; src_a = 32'd100; src_b = 32'd3; d_md_use = 1'b1;
    tick();
    md_op = 3'd0;
    tick();
    tick();
    #1;
    check("abort busy pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort hi late", hi, 32'd0);
    check("abort lo late", lo, 32'd0);
    check("abort busy late", {31'd0, busy}, 32'd0);

    reset = 1'b1; md_op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    tick();
    reset = 1'b0; md_op = 3'd0;
    #1;
    check("reset dom busy", {31'd0, busy}, 32'd0);
    tick();
    check("reset dom hi", hi, 32'd0);
    check("reset dom lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
